bit_serial_alu_ctrl: RTL and testbench

Sequencer that drives a single external 1-bit ALU slice LSB-first to perform WIDTH-bit operations. It accepts operand/opcode requests over a valid/ready handshake and feeds the slice one bit per cycle. The registered slice carry-out is chained into the next bit's carry-in, and the assembled result, carry and overflow are returned over a second valid/ready handshake. It sits between the datapath control and the slice, on the issuing side of the slice's a/b/cin/opcode interface.

---
 rtl/bit_serial_alu_ctrl_if.sv | 28 ++
 rtl/bit_serial_alu_ctrl.sv | 126 ++++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bit_serial_alu_ctrl_if.sv
// rtl/bit_serial_alu_ctrl_if.sv - request/response handshake bundle for the bit-serial ALU sequencer
interface bit_serial_alu_ctrl_if #(
   parameter int WIDTH = 8
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic             out_overflow;
   logic             out_err;

   // Issuer of requests and consumer of responses
   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_cout, out_overflow, out_err
   );

   // The sequencer itself
   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_cout, out_overflow, out_err
   );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - LSB-first sequencer for an external 1-bit ALU slice; ALU_CTRL_SUB_EN enables op 100 (subtract)
module bit_serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bit_serial_alu_ctrl_if.slave bus,
   output logic                 slice_a,
   output logic                 slice_b,
   output logic                 slice_cin,
   output logic [2:0]           slice_op,
   input  logic                 slice_result,
   input  logic                 slice_cout
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [2:0]       op_q;
   logic [IW-1:0]    idx;
   logic             carry;
   logic             cout_q, ovf_q, err_q;
   logic             accept, last_bit;
   logic             in_legal, op_arith, bit_b, carry_init;

   assign accept   = bus.in_valid & bus.in_ready;
   assign last_bit = (idx == LAST);

`ifdef ALU_CTRL_SUB_EN
   logic op_sub;
   assign in_legal   = (bus.in_op <= 3'b100);
   assign op_sub     = (op_q == 3'b100);
   assign op_arith   = (op_q == 3'b000) | op_sub;
   assign bit_b      = b_q[idx] ^ op_sub;
   assign carry_init = (bus.in_op == 3'b100);
`else
   assign in_legal   = ~bus.in_op[2];
   assign op_arith   = (op_q == 3'b000);
   assign bit_b      = b_q[idx];
   assign carry_init = 1'b0;
`endif

   assign bus.in_ready     = (state == IDLE);
   assign bus.out_valid    = (state == DONE);
   assign bus.out_result   = res_q;
   assign bus.out_cout     = cout_q;
   assign bus.out_overflow = ovf_q;
   assign bus.out_err      = err_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state: illegal ops skip RUN and report straight away
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = in_legal ? RUN : DONE;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    if (bus.out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slice drive: current bit pair and chained carry during RUN, quiet otherwise
   always_comb begin
      slice_a   = 1'b0;
      slice_b   = 1'b0;
      slice_cin = 1'b0;
      slice_op  = 3'b000;
      if (state == RUN) begin
         slice_a   = a_q[idx];
         slice_b   = bit_b;
         slice_cin = carry;
         slice_op  = op_arith ? 3'b000 : op_q;
      end
   end

   // Operand latch, bit walk, carry chain and result assembly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= 3'b000;
         idx    <= '0;
         carry  <= 1'b0;
         res_q  <= '0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q    <= bus.in_a;
                  b_q    <= bus.in_b;
                  op_q   <= bus.in_op;
                  idx    <= '0;
                  carry  <= in_legal & carry_init;
                  res_q  <= '0;
                  cout_q <= 1'b0;
                  ovf_q  <= 1'b0;
                  err_q  <= ~in_legal;
               end
            end
            RUN: begin
               res_q[idx] <= slice_result;
               carry      <= op_arith & slice_cout;
               if (last_bit) begin
                  idx    <= '0;
                  cout_q <= op_arith & slice_cout;
                  ovf_q  <= op_arith & (carry ^ slice_cout);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb/tb_bit_serial_alu_ctrl.sv - randomized self-checking bench for bit_serial_alu_ctrl with a behavioural slice
module tb_bit_serial_alu_ctrl;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic slice_a, slice_b, slice_cin, slice_result, slice_cout;
   logic [2:0] slice_op;
   int n_checks = 0;
   int n_fail = 0;

   bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus),
      .slice_a      (slice_a),
      .slice_b      (slice_b),
      .slice_cin    (slice_cin),
      .slice_op     (slice_op),
      .slice_result (slice_result),
      .slice_cout   (slice_cout)
   );

   always #5 clk = ~clk;

   // External 1-bit slice; its carry generator runs regardless of op
   always_comb begin
      slice_cout = (slice_a & slice_b) | (slice_cin & (slice_a ^ slice_b));
      case (slice_op)
         3'b000:  slice_result = slice_a ^ slice_b ^ slice_cin;
         3'b001:  slice_result = slice_a & slice_b;
         3'b010:  slice_result = slice_a | slice_b;
         3'b011:  slice_result = ~slice_a;
         default: slice_result = 1'b0;
      endcase
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Whole-word arithmetic reference
   function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                                     output logic [W-1:0] r, output logic c, output logic ov, output logic er);
      logic [W:0] s;
      r = '0; c = 1'b0; ov = 1'b0; er = 1'b0;
      case (op)
         3'd0: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[W-1:0];
            c  = s[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: r = a & b;
         3'd2: r = a | b;
         3'd3: r = ~a;
`ifdef ALU_CTRL_SUB_EN
         3'd4: begin
            r  = a - b;
            c  = (a >= b);
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
`endif
         default: er = 1'b1;
      endcase
   endfunction

   // One transaction from a negedge in IDLE; optionally presents the next request while busy
   task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input int hold,
                         input bit chain, input logic [W-1:0] na, input logic [W-1:0] nb, input logic [2:0] nop);
      logic [W-1:0] er;
      logic ec, eo, ee;
      int cyc;
      bit seen, bad_slice, bad_hold;
      ref_model(a, b, op, er, ec, eo, ee);
      bus.in_a = a; bus.in_b = b; bus.in_op = op; bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      cyc = 0;
      while (!bus.in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (!bus.in_ready) begin
         check_eq("accept_timeout", 0, 1);
         bus.in_valid = 1'b0;
         return;
      end
      cyc = 0; seen = 0; bad_slice = 0;
      while (!seen && cyc < W + 10) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            if (chain) begin
               bus.in_a = na; bus.in_b = nb; bus.in_op = nop;
            end else begin
               bus.in_valid = 1'b0;
            end
         end
         if (bus.out_valid) begin
            seen = 1;
            bad_slice |= slice_a | slice_b | slice_cin | (slice_op != 3'd0);
         end else if (op inside {3'd1, 3'd2, 3'd3}) begin
            bad_slice |= slice_cin | (slice_op != op);
         end else begin
            bad_slice |= (slice_op != 3'd0);
         end
      end
      check_eq("latency", cyc, ee ? 1 : W + 1);
      check_eq("slice_drive", bad_slice, 0);
      check_eq("result", bus.out_result, er);
      check_eq("cout", bus.out_cout, ec);
      check_eq("overflow", bus.out_overflow, eo);
      check_eq("err", bus.out_err, ee);
      check_eq("in_ready_busy", bus.in_ready, 0);
      bad_hold = 0;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         bad_hold |= !bus.out_valid || bus.in_ready || (bus.out_result != er) || (bus.out_cout != ec) ||
                     (bus.out_overflow != eo) || (bus.out_err != ee);
      end
      if (hold > 0) check_eq("hold_stable", bad_hold, 0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_eq("out_valid_drop", bus.out_valid, 0);
      check_eq("in_ready_back", bus.in_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = 3'd0; bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", bus.in_ready, 1);
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_result", bus.out_result, 0);
      check_eq("rst_flags", {bus.out_cout, bus.out_overflow, bus.out_err}, 0);
      check_eq("rst_slice", {slice_a, slice_b, slice_cin, slice_op}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      do_txn(8'h7F, 8'h01, 3'd0, 0, 0, '0, '0, 3'd0);
      do_txn(8'hFF, 8'h01, 3'd0, 0, 0, '0, '0, 3'd0);
      do_txn(8'h05, 8'h07, 3'd4, 0, 0, '0, '0, 3'd0);
      do_txn(8'h80, 8'h01, 3'd4, 0, 0, '0, '0, 3'd0);
      do_txn(8'hF0, 8'h3C, 3'd1, 0, 0, '0, '0, 3'd0);
      do_txn(8'hF0, 8'h0C, 3'd2, 0, 0, '0, '0, 3'd0);
      do_txn(8'h5A, 8'h00, 3'd3, 0, 0, '0, '0, 3'd0);
      do_txn(8'h12, 8'h34, 3'd0, 5, 1, 8'h55, 8'h66, 3'd0);
      do_txn(8'h55, 8'h66, 3'd0, 0, 0, '0, '0, 3'd0);
      do_txn(8'h00, 8'h00, 3'd7, 2, 0, '0, '0, 3'd0);
      do_txn(8'hAB, 8'hCD, 3'd5, 0, 0, '0, '0, 3'd0);

      // Reset while RUN is on bit 3 of an add
      bus.in_a = 8'hAA; bus.in_b = 8'h55; bus.in_op = 3'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) bus.in_valid = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check_eq("midrun_rst_out_valid", bus.out_valid, 0);
      check_eq("midrun_rst_in_ready", bus.in_ready, 1);
      check_eq("midrun_rst_result", bus.out_result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_txn(8'h01, 8'h02, 3'd0, 0, 0, '0, '0, 3'd0);

      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra, rb;
         logic [2:0] rop;
         ra  = W'($urandom);
         rb  = W'($urandom);
         rop = (i % 4 == 3) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
         do_txn(ra, rb, rop, int'($urandom_range(0, 2)), 0, '0, '0, 3'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
